// File: rtl/controlador_entrada_rpn.sv
// controlador_entrada_rpn: debounced button/switch front-end that issues single-cycle commands to sistema_rpn.
module controlador_entrada_rpn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] chaves,
  input  logic [2:0] seletor_op,
  input  logic       botao_numero,
  input  logic       botao_operacao,
  input  logic       botao_executar,
  output logic [7:0] entrada,
  output logic [2:0] operacao,
  output logic       entrada_numero,
  output logic       entrada_operacao,
  output logic       executar,
  output logic       erro_sequencia,
  output logic [1:0] contagem_operandos,
  output logic       ocupado
);
  typedef enum logic [1:0] {OCIOSO, FILTRANDO, EMITINDO, AGUARDA_SOLTAR} estado_t;
  localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES - 1);
  estado_t    r_estado, w_prox;
  logic [2:0] r_sync1, r_sync2;
  logic [7:0] r_cont, w_cont;
  logic [1:0] r_sel, w_sel;
  logic [7:0] r_entrada, w_entrada;
  logic [2:0] r_operacao, w_operacao;
  logic [3:0] r_pulsos, w_pulsos;
  logic [1:0] r_contagem, w_contagem;
  logic       r_ocupado;
  logic       w_qualquer, w_ativo, w_op_ok;
  assign w_qualquer = |r_sync2;
  assign w_ativo = (r_sel == 2'd0) ? r_sync2[0] : (r_sel == 2'd1) ? r_sync2[1] : r_sync2[2];
  assign w_op_ok = r_contagem == 2'd2;
  always_comb begin
    w_prox = r_estado;
    w_cont = r_cont;
    w_sel = r_sel;
    w_entrada = r_entrada;
    w_operacao = r_operacao;
    w_pulsos = '0;
    w_contagem = r_contagem;
    case (r_estado)
      OCIOSO:
        if (w_qualquer) begin
          w_prox = FILTRANDO;
          w_cont = 8'd1;
          w_sel = r_sync2[0] ? 2'd0 : r_sync2[1] ? 2'd1 : 2'd2;
        end
      FILTRANDO:
        if (!w_ativo) w_prox = OCIOSO;
        else if (r_cont != LIM) w_cont = r_cont + 8'd1;
        else begin
          w_prox = EMITINDO;
          w_entrada = chaves;
          // a rejected operation leaves the pending operation code untouched
          w_operacao = (r_sel == 2'd1 && !w_op_ok) ? r_operacao : seletor_op;
          w_pulsos[0] = r_sel == 2'd0;
          w_pulsos[1] = r_sel == 2'd1 && w_op_ok;
          w_pulsos[2] = r_sel == 2'd2;
          w_pulsos[3] = r_sel == 2'd1 && !w_op_ok;
          w_contagem = (r_sel == 2'd0) ? (w_op_ok ? 2'd2 : r_contagem + 2'd1) :
                       (r_sel == 2'd1 && w_op_ok) ? 2'd1 : r_contagem;
        end
      EMITINDO: begin
        w_prox = AGUARDA_SOLTAR;
        w_cont = 8'd0;
      end
      AGUARDA_SOLTAR:
        if (w_qualquer) w_cont = 8'd0;
        else if (r_cont == LIM) w_prox = OCIOSO;
        else w_cont = r_cont + 8'd1;
      default: w_prox = OCIOSO;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_estado <= OCIOSO;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cont <= '0;
      r_sel <= '0;
      r_entrada <= '0;
      r_operacao <= '0;
      r_pulsos <= '0;
      r_contagem <= '0;
      r_ocupado <= 1'b0;
    end else begin
      r_sync1 <= {botao_executar, botao_operacao, botao_numero};
      r_sync2 <= r_sync1;
      r_estado <= w_prox;
      r_cont <= w_cont;
      r_sel <= w_sel;
      r_entrada <= w_entrada;
      r_operacao <= w_operacao;
      r_pulsos <= w_pulsos;
      r_contagem <= w_contagem;
      r_ocupado <= w_prox != OCIOSO;
    end
  assign entrada = r_entrada;
  assign operacao = r_operacao;
  assign {erro_sequencia, executar, entrada_operacao, entrada_numero} = r_pulsos;
  assign contagem_operandos = r_contagem;
  assign ocupado = r_ocupado;
endmodule
